// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one memory port and the
// fifo_if MMIO port, with starvation control and 1-cycle response routing.
module mem_arbiter #(
   parameter logic [3:0]  MMIO_NIBBLE = 4'hF,
   parameter int unsigned STARVE_MAX  = 3
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   output logic        if_err_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   input  logic [3:0]  d_be_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic [31:0] d_rdata_o,
   output logic        mem_en_o,
   output logic [3:0]  mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   output logic        mmio_sel_o,
   output logic        mmio_read_o,
   output logic        mmio_write_o,
   output logic [1:0]  mmio_addr_o,
   output logic [7:0]  mmio_wdata_o,
   input  logic [7:0]  mmio_rdata_i
);

   typedef enum logic [2:0] {
      RESP_NONE,
      RESP_IF_MEM,
      RESP_IF_ERR,
      RESP_D_MEM,
      RESP_D_MMIO
   } resp_t;

   localparam logic [2:0]  LP_STARVE_MAX = 3'(STARVE_MAX);
   localparam logic [31:0] LP_NOP        = 32'h0000_0013;

   resp_t       r_resp;
   resp_t       w_resp_nxt;
   logic [2:0]  r_starve_cnt;
   logic [2:0]  w_starve_nxt;
   logic        w_if_mmio;
   logic        w_d_mmio;
   logic        w_if_win;
   logic        w_d_win;
   logic        w_unused;

   // Byte offsets within a word carry no meaning for either target.
   assign w_unused  = ^{if_addr_i[1:0], d_addr_i[1:0]};

   assign w_if_mmio = (if_addr_i[31:28] == MMIO_NIBBLE);
   assign w_d_mmio  = (d_addr_i[31:28] == MMIO_NIBBLE);

   // Grants are qualified with rstn_i so nothing leaks out while in reset.
   assign w_if_win  = rstn_i && if_req_i &&
                      (!d_req_i || (r_starve_cnt == LP_STARVE_MAX));
   assign w_d_win   = rstn_i && d_req_i && !w_if_win;

   assign if_gnt_o  = w_if_win;
   assign d_gnt_o   = w_d_win;

   always_comb begin
      w_resp_nxt   = RESP_NONE;
      mem_en_o     = 1'b0;
      mem_we_o     = 4'b0000;
      mem_addr_o   = 32'h0;
      mem_wdata_o  = 32'h0;
      mmio_sel_o   = 1'b0;
      mmio_read_o  = 1'b0;
      mmio_write_o = 1'b0;
      mmio_addr_o  = 2'b00;
      mmio_wdata_o = 8'h00;
      if (w_if_win) begin
         mem_addr_o = {if_addr_i[31:2], 2'b00};
         if (w_if_mmio) begin
            w_resp_nxt = RESP_IF_ERR;
         end else begin
            mem_en_o   = 1'b1;
            w_resp_nxt = RESP_IF_MEM;
         end
      end else if (w_d_win) begin
         if (w_d_mmio) begin
            mmio_addr_o  = d_addr_i[3:2];
            mmio_wdata_o = d_wdata_i[7:0];
            if (d_we_i) begin
               // The FIFO register is one byte wide; stores missing lane 0 are dropped.
               mmio_sel_o   = d_be_i[0];
               mmio_write_o = d_be_i[0];
            end else begin
               mmio_sel_o   = 1'b1;
               mmio_read_o  = 1'b1;
               w_resp_nxt   = RESP_D_MMIO;
            end
         end else begin
            mem_en_o    = 1'b1;
            mem_addr_o  = {d_addr_i[31:2], 2'b00};
            mem_wdata_o = d_wdata_i;
            if (d_we_i) begin
               mem_we_o = d_be_i;
            end else begin
               w_resp_nxt = RESP_D_MEM;
            end
         end
      end
   end

   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (!if_req_i || w_if_win) begin
         w_starve_nxt = 3'd0;
      end else if (r_starve_cnt != LP_STARVE_MAX) begin
         w_starve_nxt = r_starve_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_resp       <= RESP_NONE;
         r_starve_cnt <= 3'd0;
      end else begin
         r_resp       <= w_resp_nxt;
         r_starve_cnt <= w_starve_nxt;
      end
   end

   // Response routing: rdata is zero whenever its rvalid is low.
   always_comb begin
      if_rvalid_o = 1'b0;
      if_err_o    = 1'b0;
      if_rdata_o  = 32'h0;
      d_rvalid_o  = 1'b0;
      d_rdata_o   = 32'h0;
      case (r_resp)
         RESP_IF_MEM: begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
         end
         RESP_IF_ERR: begin
            if_rvalid_o = 1'b1;
            if_err_o    = 1'b1;
            if_rdata_o  = LP_NOP;
         end
         RESP_D_MEM: begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = mem_rdata_i;
         end
         RESP_D_MMIO: begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = {24'h0, mmio_rdata_i};
         end
         default: begin
            if_rvalid_o = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single synchronous memory port and the `fifo_if` MMIO port between the CPU's instruction-fetch and data (load/store) requesters. It performs address decode, arbitration, starvation control and response routing, and sits between `control`/PC logic and the memory and FIFO blocks. It allows one outstanding access, supports back-to-back grants, and returns read data exactly one cycle after the grant.

## Interface
Parameters:
- `MMIO_NIBBLE`, default 4'hF: value of `addr[31:28]` that selects the MMIO region.
- `STARVE_MAX`, default 3: number of consecutive fetch-denied cycles (1..7) after which fetch wins the next contention.

Ports (single clock; reset is asynchronous, active-low):
- `clk_i` in 1: clock, all state on rising edge.
- `rstn_i` in 1: asynchronous active-low reset.
- `if_req_i` in 1: fetch request, held until granted.
- `if_addr_i` in 32: fetch address.
- `if_gnt_o` out 1: fetch granted this cycle.
- `if_rvalid_o` out 1: fetch response valid.
- `if_rdata_o` out 32: fetch data.
- `if_err_o` out 1: fetch response is an error.
- `d_req_i` in 1: data request, held until granted.
- `d_we_i` in 1: 1 = store.
- `d_addr_i` in 32: data address.
- `d_wdata_i` in 32: store data.
- `d_be_i` in 4: store byte enables.
- `d_gnt_o` out 1: data granted this cycle.
- `d_rvalid_o` out 1: load response valid (loads only).
- `d_rdata_o` out 32: load data.
- `mem_en_o` out 1: memory access strobe.
- `mem_we_o` out 4: byte write enables.
- `mem_addr_o` out 32: word address, byte-addressed with `[1:0]` = 0.
- `mem_wdata_o` out 32: write data.
- `mem_rdata_i` in 32: read data, valid the cycle after `mem_en_o`.
- `mmio_sel_o` out 1, `mmio_read_o` out 1, `mmio_write_o` out 1: `fifo_if` strobes.
- `mmio_addr_o` out 2: register index, `d_addr_i[3:2]`.
- `mmio_wdata_o` out 8: `d_wdata_i[7:0]`.
- `mmio_rdata_i` in 8: register data, valid the cycle after `mmio_read_o`.

## Operation
Decode:
- The MMIO region is `addr[31:28] == MMIO_NIBBLE`; everything else is memory.
- The address LSBs `[1:0]` are ignored. `mem_addr_o = {addr[31:2],2'b00}`.

Arbitration (combinational, same cycle as the request):
- Only one requester: it is granted.
- Both requesting: data wins, unless `starve_cnt == STARVE_MAX`, in which case fetch wins.
- `starve_cnt` is a 3-bit counter:
  - increments (saturating at `STARVE_MAX`) each cycle `if_req_i && !if_gnt_o`;
  - clears on a fetch grant or whenever `if_req_i` = 0.
- The grant is never withheld when the selected target is free. Both targets are always free because there is one outstanding access and a 1-cycle response.

Access on grant:
- Memory load or fetch: `mem_en_o` = 1, `mem_we_o` = 0.
- Memory store: `mem_en_o` = 1, `mem_we_o = d_be_i`.
- MMIO load: `mmio_sel_o` = 1, `mmio_read_o` = 1.
- MMIO store: `mmio_sel_o` = 1, `mmio_write_o` = 1, but only if `d_be_i[0]` = 1; otherwise the store is dropped silently.
- Fetch to MMIO: no target strobe. The response has `if_err_o` = 1 and `if_rdata_o` = 32'h0000_0013 (NOP).

Response tracking:
- Registered `resp_q` state is one of `NONE`, `IF_MEM`, `IF_ERR`, `D_MEM`, `D_MMIO`. It is loaded on each cycle from the grant made in that cycle. Stores load `NONE`.
- `if_rvalid_o` = (`resp_q` is `IF_MEM` or `IF_ERR`).
- `d_rvalid_o` = (`resp_q` is `D_MEM` or `D_MMIO`).
- `D_MMIO` data is `{24'b0, mmio_rdata_i}`. Memory data passes `mem_rdata_i` through.
- When the matching rvalid is 0, the corresponding rdata output is 0.

## Timing
- Grant, target strobes and `mem_*`/`mmio_*` outputs are combinational from the requests and `starve_cnt`.
- Read latency is exactly 1 cycle, grant to rvalid. A new grant is allowed in the same cycle as the previous response, giving a throughput of 1 access per cycle.
- A store completes in its grant cycle, with no response.
- Reset values, asserted asynchronously while `rstn_i` = 0:
  - `resp_q = NONE`, `starve_cnt` = 0;
  - every output 0, except the combinational grants, which are forced to 0 during reset.
- Reset during an outstanding read: the response is dropped, and no rvalid follows reset release.
- A request deasserted before its grant is legal and leaves no state.

## Test plan
- Fetch-only, addresses 0x0,0x4,0x8 on consecutive cycles, memory returns 0xA,0xB,0xC -> `if_gnt_o` high 3 cycles; `if_rvalid_o` high 3 cycles starting 1 cycle later, with data 0xA,0xB,0xC.
- Data and fetch requesting continuously, `STARVE_MAX` = 3 -> grant pattern D,D,D,IF repeating; `starve_cnt` clears after each IF grant.
- Store to 0x100 with `d_wdata_i` 0x11223344 and `d_be_i` 4'b0011 -> `mem_we_o` = 4'b0011, `mem_addr_o` = 0x100, and no `d_rvalid_o`.
- MMIO load at 0xF0000004, with `mmio_rdata_i` = 0x5A -> `mmio_read_o` high with `mmio_addr_o` = 1; the next cycle shows `d_rvalid_o` = 1 and `d_rdata_o` = 0x0000005A.
- Fetch at 0xF0000000 -> no strobes; the next cycle shows `if_rvalid_o` = 1, `if_err_o` = 1 and `if_rdata_o` = 0x00000013.
- Load granted, then `rstn_i` pulsed low before the next edge -> all outputs 0, and no rvalid after release.
